l1_ahb_mtx_in_stage: RTL and testbench

//  Master-side input stage of the L1 AHB bus matrix; one instance per master port.
//  - Registers a master address phase that the output-stage arbiter cannot take

---
 rtl/l1_ahb_mtx_pkg.sv | 30 +++
 rtl/l1_ahb_mtx_hold_reg.sv | 56 +++++
 rtl/l1_ahb_mtx_in_stage.sv | 123 ++++++++++++
 tb/tb_l1_ahb_mtx_in_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/l1_ahb_mtx_pkg.sv
// Shared definitions for the L1 AHB bus matrix: HTRANS/HBURST codes, the
// input-stage FSM encoding and the address-phase control bundle that the
// input stage holds while a transfer waits for its output-stage arbiter.
package l1_ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PEND = 2'b01,
    S_DATA = 2'b10
  } in_state_t;

  // Address-phase controls; the address is kept separate so its width can
  // follow ADDR_W.
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

endpackage

// File: rtl/l1_ahb_mtx_hold_reg.sv
// Holding register for one master address phase.
//  clk, rst      : clock, asynchronous active-high reset
//  capture       : load cap_addr/cap_ctrl and set pend_q (ignored while pending)
//  accept        : output stage took the held phase; clears pend_q and contents
//  pend_q        : a held address phase is waiting
//  addr_q/ctrl_q : held address phase
module l1_ahb_mtx_hold_reg
  import l1_ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              accept,
  input  logic [ADDR_W-1:0] cap_addr,
  input  ahb_ctrl_t         cap_ctrl,
  output logic              pend_q,
  output logic [ADDR_W-1:0] addr_q,
  output ahb_ctrl_t         ctrl_q
);

  logic              pend_d;
  logic [ADDR_W-1:0] addr_d;
  ahb_ctrl_t         ctrl_d;

  // Contents are frozen while pending so the replayed phase is exactly what
  // the master issued.
  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    ctrl_d = ctrl_q;
    if (!pend_q && capture) begin
      pend_d = 1'b1;
      addr_d = cap_addr;
      ctrl_d = cap_ctrl;
    end else if (pend_q && accept) begin
      pend_d = 1'b0;
      addr_d = '0;
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      ctrl_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      ctrl_q <= ctrl_d;
    end
  end

endmodule

// File: rtl/l1_ahb_mtx_in_stage.sv
// Master-side input stage of the L1 AHB bus matrix (one per master port).
// Presents the live address phase to the output stages, or a held copy when
// the arbiter could not take it at once, and stalls the master until the
// granted data phase completes.
//  HCLK/HRESET          : clock, asynchronous active-high reset
//  HSELS..HREADYS       : master address phase and bus HREADY
//  HREADYOUTS/HRESPS    : ready/response returned to the master
//  sel_out..lock_out    : address phase presented to output stages
//  req_out              : request to output-stage arbiter
//  addr_accept          : output stage takes the presented phase this cycle
//  readyout_m/resp_m    : data-phase response from the granted output stage
module l1_ahb_mtx_in_stage
  import l1_ahb_mtx_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BURST_REMAP = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        trans_out,
  output logic              write_out,
  output logic [2:0]        size_out,
  output logic [2:0]        burst_out,
  output logic [3:0]        prot_out,
  output logic              lock_out,
  output logic              req_out,
  input  logic              addr_accept,
  input  logic              readyout_m,
  input  logic              resp_m
);

  in_state_t         state_q, state_d;
  logic              live_valid, boundary, capture, pend_q;
  logic [ADDR_W-1:0] hold_addr;
  ahb_ctrl_t         hold_ctrl, live_ctrl, pres_ctrl;

  assign live_ctrl  = '{trans: HTRANSS, write: HWRITES, size: HSIZES,
                        burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};
  assign live_valid = HSELS & HREADYS & HTRANSS[1];
  // A new address phase can only be registered when no data phase is stalling.
  assign boundary   = (state_q == S_IDLE) | ((state_q == S_DATA) & readyout_m);
  assign capture    = boundary & live_valid & ~addr_accept;
  assign req_out    = pend_q | live_valid;

  l1_ahb_mtx_hold_reg #(.ADDR_W(ADDR_W)) u_hold (
    .clk      (HCLK),
    .rst      (HRESET),
    .capture  (capture),
    .accept   (addr_accept),
    .cap_addr (HADDRS),
    .cap_ctrl (live_ctrl),
    .pend_q   (pend_q),
    .addr_q   (hold_addr),
    .ctrl_q   (hold_ctrl)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (live_valid) state_d = addr_accept ? S_DATA : S_PEND;
      end
      S_PEND: begin
        HREADYOUTS = 1'b0;
        if (addr_accept) state_d = S_DATA;
      end
      S_DATA: begin
        HREADYOUTS = readyout_m;
        HRESPS     = resp_m;
        if (readyout_m) begin
          if (live_valid) state_d = addr_accept ? S_DATA : S_PEND;
          else            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Held SEQ beats are replayed as NONSEQ/INCR: another master may have owned
  // the slave in between, so the burst cannot be assumed to continue.
  always_comb begin
    pres_ctrl = live_ctrl;
    sel_out   = HSELS & HREADYS;
    addr_out  = HADDRS;
    if (pend_q) begin
      pres_ctrl = hold_ctrl;
      sel_out   = 1'b1;
      addr_out  = hold_addr;
      if ((BURST_REMAP != 0) && (hold_ctrl.trans == HTRANS_SEQ)) begin
        pres_ctrl.trans = HTRANS_NONSEQ;
        pres_ctrl.burst = HBURST_INCR;
      end
    end
  end

  assign trans_out = pres_ctrl.trans;
  assign write_out = pres_ctrl.write;
  assign size_out  = pres_ctrl.size;
  assign burst_out = pres_ctrl.burst;
  assign prot_out  = pres_ctrl.prot;
  assign lock_out  = pres_ctrl.lock;

endmodule

// File: tb/tb_l1_ahb_mtx_in_stage.sv
module tb_l1_ahb_mtx_in_stage;

  logic        HCLK = 1'b0;
  logic        HRESET, HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYOUTS, HRESPS, sel_out, write_out, lock_out, req_out;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic [2:0]  size_out, burst_out;
  logic [3:0]  prot_out;
  logic        addr_accept, readyout_m, resp_m;

  always #5 HCLK = ~HCLK;

  l1_ahb_mtx_in_stage #(.ADDR_W(32), .BURST_REMAP(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_out(sel_out),
    .addr_out(addr_out), .trans_out(trans_out), .write_out(write_out),
    .size_out(size_out), .burst_out(burst_out), .prot_out(prot_out),
    .lock_out(lock_out), .req_out(req_out), .addr_accept(addr_accept),
    .readyout_m(readyout_m), .resp_m(resp_m)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } ap_t;

  typedef struct packed {
    logic rdy, resp, req, sel;
    ap_t  ap;
  } exp_t;

  localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  exp_t sb_q[$];     // expected per-cycle outputs, popped by the monitor
  ap_t  waiting[$];  // model: address phase the master issued but nobody took
  bit   in_data;     // model: a granted data phase is in progress
  int   n_chk = 0, n_fail = 0;

  function automatic ap_t mk(logic [31:0] a, logic [1:0] t, logic w, logic [2:0] b);
    ap_t p;
    p.addr = a; p.trans = t; p.write = w; p.size = 3'd2;
    p.burst = b; p.prot = 4'h3; p.lock = 1'b0;
    return p;
  endfunction

  // Ready the master sees: stalled while its phase waits, follows the slave in
  // a data phase, otherwise zero-wait.
  function automatic logic model_ready(logic rdy);
    if (waiting.size() != 0) return 1'b0;
    if (in_data) return rdy;
    return 1'b1;
  endfunction

  function automatic exp_t model_out(logic sel, ap_t ap, logic hrdy, logic rdy, logic resp);
    exp_t e;
    e.rdy  = model_ready(rdy);
    e.resp = (waiting.size() == 0 && in_data) ? resp : 1'b0;
    e.req  = (waiting.size() != 0) || (sel && hrdy && ap.trans[1]);
    e.sel  = sel & hrdy;
    e.ap   = ap;
    if (waiting.size() != 0) begin
      e.sel = 1'b1;
      e.ap  = waiting[0];
      if (e.ap.trans == T_SEQ) begin
        e.ap.trans = T_NSEQ;
        e.ap.burst = 3'b001;
      end
    end
    return e;
  endfunction

  task automatic cyc(input logic sel, input ap_t ap, input logic acc, input logic rdy, input logic resp);
    logic hr, issued;
    hr = model_ready(rdy);
    HSELS = sel; HADDRS = ap.addr; HTRANSS = ap.trans; HWRITES = ap.write;
    HSIZES = ap.size; HBURSTS = ap.burst; HPROTS = ap.prot; HMASTLOCKS = ap.lock;
    HREADYS = hr; addr_accept = acc; readyout_m = rdy; resp_m = resp;
    sb_q.push_back(model_out(sel, ap, hr, rdy, resp));
    @(posedge HCLK);
    issued = sel && hr && ap.trans[1];
    if (waiting.size() != 0) begin
      if (acc) begin
        waiting.delete(0);
        in_data = 1'b1;
      end
    end else if (!in_data || rdy) begin
      in_data = issued && acc;
      if (issued && !acc) waiting.push_back(ap);
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    HSELS = 1'b0; HTRANSS = T_IDLE; HREADYS = 1'b1; addr_accept = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("rst_hreadyout", {31'd0, HREADYOUTS}, 32'd1);
    chk("rst_hresp",     {31'd0, HRESPS},     32'd0);
    chk("rst_req",       {31'd0, req_out},    32'd0);
    chk("rst_sel",       {31'd0, sel_out},    32'd0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    waiting.delete();
    in_data = 1'b0;
  endtask

  always @(negedge HCLK) begin
    exp_t e, a;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      a = {HREADYOUTS, HRESPS, req_out, sel_out, addr_out, trans_out, write_out,
           size_out, burst_out, prot_out, lock_out};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got %h required %h", $time, a, e);
      end
    end
  end

  initial begin
    ap_t idle_ap, r;
    idle_ap = mk(32'h0, T_IDLE, 1'b0, 3'b000);
    HRESET = 1'b1; HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HSIZES = 0;
    HBURSTS = 0; HPROTS = 0; HMASTLOCKS = 0; HREADYS = 1; addr_accept = 0;
    readyout_m = 0; resp_m = 0;
    in_data = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("init_hreadyout", {31'd0, HREADYOUTS}, 32'd1);
    chk("init_req",       {31'd0, req_out},    32'd0);
    HRESET = 1'b0;

    // Reset while a transfer is pending: discarded, never replayed.
    cyc(1, mk(32'h3000_0000, T_NSEQ, 1, 3'b000), 0, 0, 0);
    cyc(0, idle_ap, 0, 0, 0);
    do_reset();
    cyc(0, idle_ap, 1, 1, 0);
    cyc(0, idle_ap, 1, 1, 0);

    // Live write accepted at once, then two data-phase waits.
    cyc(1, mk(32'h2000_0010, T_NSEQ, 1, 3'b000), 1, 1, 0);
    cyc(1, idle_ap, 0, 0, 0);
    cyc(1, idle_ap, 0, 0, 0);
    cyc(1, idle_ap, 0, 1, 0);

    // Read held for three cycles of addr_accept low.
    cyc(1, mk(32'h1000_0000, T_NSEQ, 0, 3'b000), 0, 1, 0);
    cyc(1, idle_ap, 0, 1, 0);
    cyc(1, idle_ap, 0, 1, 0);
    cyc(1, idle_ap, 1, 1, 0);
    cyc(1, idle_ap, 0, 0, 0);
    cyc(1, idle_ap, 0, 1, 0);

    // INCR4 second beat held: replayed as NONSEQ/INCR.
    cyc(1, mk(32'h4000_0000, T_NSEQ, 1, 3'b011), 1, 1, 0);
    cyc(1, mk(32'h4000_0004, T_SEQ,  1, 3'b011), 0, 1, 0);
    cyc(1, idle_ap, 0, 1, 0);
    cyc(1, idle_ap, 0, 1, 0);
    cyc(1, idle_ap, 1, 1, 0);
    cyc(1, idle_ap, 0, 1, 0);

    // Two-cycle ERROR passed through, master goes IDLE.
    cyc(1, mk(32'h5000_0000, T_NSEQ, 0, 3'b000), 1, 1, 0);
    cyc(1, idle_ap, 0, 0, 1);
    cyc(1, idle_ap, 0, 1, 1);
    cyc(1, idle_ap, 0, 1, 0);

    // Back-to-back accepted transfers, no wait inserted.
    cyc(1, mk(32'h6000_0000, T_NSEQ, 1, 3'b000), 1, 1, 0);
    cyc(1, mk(32'h6000_0100, T_NSEQ, 0, 3'b000), 1, 1, 0);
    cyc(1, idle_ap, 0, 1, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r.addr  = $urandom;
      r.trans = 2'($urandom_range(0, 3));
      r.write = 1'($urandom);
      r.size  = 3'($urandom_range(0, 2));
      r.burst = 3'($urandom_range(0, 7));
      r.prot  = 4'($urandom);
      r.lock  = 1'($urandom_range(0, 9) == 0);
      cyc(1'($urandom_range(0, 9) < 8), r, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 2));
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    @(negedge HCLK);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
